// File: rtl/cdc_handshake_tx.sv
// Sending side of a 4-phase req/ack handshake: registers a word, raises req_out, and waits for
// the synchronized acknowledge to rise and fall, with an optional per-phase timeout.
module cdc_handshake_tx #(
  parameter int DATA_WIDTH     = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  send,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  ack_in,
  output logic                  req_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_RELEASE = 2'd2
  } state_e;

  localparam bit          HAS_TO   = (TIMEOUT_CYCLES != 0);
  localparam int          CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = HAS_TO ? CW'(TIMEOUT_CYCLES - 1) : '0;

  state_e                  state_q, state_d;
  logic                    req_q, req_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    done_q, done_d;
  logic                    timeout_q, timeout_d;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    ack_sync;
  logic                    at_limit;

  // ack_in is asynchronous; only the last stage of this chain may feed the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], ack_in};
  end

  assign ack_sync = sync_q[SYNC_STAGES-1];
  assign at_limit = HAS_TO && (cnt_q == CNT_LAST);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d   = state_q;
    req_d     = req_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (send) begin
          data_d  = data_in;
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        // An acknowledge seen on the last allowed cycle still wins over the timeout.
        if (ack_sync) begin
          req_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_RELEASE;
        end else if (at_limit) begin
          req_d     = 1'b0;
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else if (HAS_TO) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RELEASE: begin
        if (!ack_sync) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (at_limit) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else if (HAS_TO) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      req_q     <= 1'b0;
      data_q    <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  assign req_out  = req_q;
  assign data_out = data_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed and randomized checks of cdc_handshake_tx against edge-count arithmetic derived
// from the handshake latency and timeout rules.
`timescale 1ns/1ps
module tb_cdc_handshake_tx;

  localparam int DW = 8;
  localparam int SS = 2;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          send;
  logic [DW-1:0] data_in;
  logic          ack_in;
  logic          req_out;
  logic [DW-1:0] data_out;
  logic          busy;
  logic          done;
  logic          timeout;

  int total = 0;
  int bad   = 0;

  int   done_cnt = 0;
  int   to_cnt   = 0;
  int   both_cnt = 0;
  int   rise_cnt = 0;
  logic req_prev = 1'b0;

  always #5 clk = ~clk;

  cdc_handshake_tx #(
    .DATA_WIDTH    (DW),
    .SYNC_STAGES   (SS),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .send    (send),
    .data_in (data_in),
    .ack_in  (ack_in),
    .req_out (req_out),
    .data_out(data_out),
    .busy    (busy),
    .done    (done),
    .timeout (timeout)
  );

  // Event counters sampled mid-cycle.
  always @(negedge clk) begin
    if (done)              done_cnt++;
    if (timeout)           to_cnt++;
    if (done && timeout)   both_cnt++;
    if (req_out && !req_prev) rise_cnt++;
    req_prev = req_out;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic r, input logic b, input logic d,
                            input logic t, input logic [DW-1:0] dat);
    check({tag, ".req"},     32'(req_out),  32'(r));
    check({tag, ".busy"},    32'(busy),     32'(b));
    check({tag, ".done"},    32'(done),     32'(d));
    check({tag, ".timeout"}, 32'(timeout),  32'(t));
    check({tag, ".data"},    32'(data_out), 32'(dat));
  endtask

  task automatic wait_req(input logic v, input string tag);
    int n;
    n = 0;
    while (req_out !== v && n < 20) begin
      tick();
      n++;
    end
    check(tag, 32'(req_out), 32'(v));
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check(tag, 32'(done), 32'(1'b1));
  endtask

  logic [DW-1:0] words [3];
  logic [DW-1:0] w;
  int d0, t0, r0;
  int d_ack, d_rel, a, b, end_c, req_end, ack_off, t;
  bit hs, rel_done;

  initial begin
    words = '{8'h01, 8'h02, 8'h03};

    // 1. Power-on reset, with send asserted during reset.
    rst = 1'b1; send = 1'b1; data_in = 8'hFF; ack_in = 1'b0;
    #2;
    check_outs("rst_async", 0, 0, 0, 0, 8'h00);
    tick(); tick();
    check_outs("rst_held", 0, 0, 0, 0, 8'h00);
    #3;
    rst = 1'b0; send = 1'b0;
    #1;
    check_outs("rst_release", 0, 0, 0, 0, 8'h00);
    tick();
    check_outs("rst_idle", 0, 0, 0, 0, 8'h00);

    // 2./3. Normal transfer with an ignored send during the handshake.
    d0 = done_cnt; r0 = rise_cnt;
    data_in = 8'hA5; send = 1'b1;
    tick();
    check_outs("xfer_accept", 1, 1, 0, 0, 8'hA5);
    data_in = 8'h3C; send = 1'b1; ack_in = 1'b1;
    tick(); check_outs("xfer_ack1", 1, 1, 0, 0, 8'hA5);
    tick(); check_outs("xfer_ack2", 1, 1, 0, 0, 8'hA5);
    tick(); check_outs("xfer_reqfall", 0, 1, 0, 0, 8'hA5);
    ack_in = 1'b0; send = 1'b0;
    tick(); check_outs("xfer_rel1", 0, 1, 0, 0, 8'hA5);
    tick(); check_outs("xfer_rel2", 0, 1, 0, 0, 8'hA5);
    tick(); check_outs("xfer_done", 0, 0, 1, 0, 8'hA5);
    tick(); check_outs("xfer_after", 0, 0, 0, 0, 8'hA5);
    check("xfer_done_count", done_cnt - d0, 1);
    check("xfer_req_rises", rise_cnt - r0, 1);

    // 4. Timeout in REQ with ack never arriving.
    d0 = done_cnt; t0 = to_cnt;
    data_in = 8'h5A; send = 1'b1;
    tick();
    check_outs("to_accept", 1, 1, 0, 0, 8'h5A);
    send = 1'b0;
    for (int j = 1; j <= TO; j++) begin
      tick();
      if (j < TO) check_outs($sformatf("to_wait%0d", j), 1, 1, 0, 0, 8'h5A);
      else        check_outs("to_fire", 0, 0, 0, 1, 8'h5A);
    end
    tick();
    check_outs("to_after", 0, 0, 0, 0, 8'h5A);
    check("to_count", to_cnt - t0, 1);
    check("to_no_done", done_cnt - d0, 0);

    // 5. Back-to-back transfers with send held high and a 3-cycle responder turnaround.
    d0 = done_cnt;
    data_in = words[0]; send = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_req(1'b1, $sformatf("b2b_req_rise%0d", i));
      check($sformatf("b2b_data%0d", i), 32'(data_out), 32'(words[i]));
      if (i < 2) data_in = words[i+1];
      else       send = 1'b0;
      repeat (3) tick();
      ack_in = 1'b1;
      wait_req(1'b0, $sformatf("b2b_req_fall%0d", i));
      repeat (3) tick();
      ack_in = 1'b0;
      wait_done($sformatf("b2b_done%0d", i));
      check_outs($sformatf("b2b_donecyc%0d", i), 0, 0, 1, 0, words[i]);
      if (i < 2) begin
        tick();
        check_outs($sformatf("b2b_next%0d", i), 1, 1, 0, 0, words[i+1]);
      end
    end
    tick();
    check_outs("b2b_end", 0, 0, 0, 0, 8'h03);
    check("b2b_done_count", done_cnt - d0, 3);

    // 6. Reset asserted in REQ aborts silently; a fresh transfer then completes.
    data_in = 8'h77; send = 1'b1;
    tick();
    check_outs("mid_accept", 1, 1, 0, 0, 8'h77);
    send = 1'b0;
    tick();
    d0 = done_cnt; t0 = to_cnt;
    #2;
    rst = 1'b1;
    #1;
    check_outs("mid_rst", 0, 0, 0, 0, 8'h00);
    tick(); tick();
    #2;
    rst = 1'b0;
    tick(); tick();
    check("mid_no_done", done_cnt - d0, 0);
    check("mid_no_timeout", to_cnt - t0, 0);
    data_in = 8'hC3; send = 1'b1;
    tick();
    check_outs("mid_fresh", 1, 1, 0, 0, 8'hC3);
    send = 1'b0; ack_in = 1'b1;
    wait_req(1'b0, "mid_fresh_reqfall");
    ack_in = 1'b0;
    wait_done("mid_fresh_done");
    check("mid_fresh_data", 32'(data_out), 32'(8'hC3));
    tick();

    // Randomized transfers: expected edges follow from "ack seen SYNC_STAGES+1 edges after it
    // changes" and "each phase gives up after TIMEOUT_CYCLES edges".
    for (int n = 0; n < 24; n++) begin
      w     = 8'($urandom);
      d_ack = $urandom_range(0, 16);
      d_rel = $urandom_range(0, 15);
      a     = d_ack + SS + 1;
      hs    = (a <= TO);
      if (hs) begin
        b        = d_rel + SS + 1;
        rel_done = (b <= TO);
        end_c    = a + (rel_done ? b : TO);
        req_end  = a;
        ack_off  = rel_done ? (a + d_rel) : end_c;
      end else begin
        b        = 0;
        rel_done = 1'b0;
        end_c    = TO;
        req_end  = TO;
        ack_off  = end_c;
      end
      data_in = w; send = 1'b1;
      tick();
      check_outs($sformatf("rnd%0d_accept", n), 1, 1, 0, 0, w);
      for (int j = 1; j <= end_c; j++) begin
        t       = j - 1;
        ack_in  = (t >= d_ack) && (t < ack_off);
        send    = 1'($urandom_range(0, 1));
        data_in = 8'($urandom);
        tick();
        check_outs($sformatf("rnd%0d_c%0d", n, j), j < req_end, j < end_c,
                   (hs && rel_done && j == end_c), (j == end_c) && !(hs && rel_done), w);
      end
      ack_in = 1'b0; send = 1'b0;
      repeat (SS + 1) begin
        tick();
        check_outs($sformatf("rnd%0d_idle", n), 0, 0, 0, 0, w);
      end
    end

    check("never_done_and_timeout", both_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
